// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// the instruction memory or cache.
interface fetch_stage_if;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        imemDone;
  logic        imemStall;
  logic        imemErr;

  modport master (
    output imemReq, imemAddr,
    input  imemData, imemDone, imemStall, imemErr
  );

  modport slave (
    input  imemReq, imemAddr,
    output imemData, imemDone, imemStall, imemErr
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory handshake, and
// presents one instruction (or a NOP bubble) to the fetch-to-decode register.
// Handles memory misses, hazard stalls, redirects and HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallF,
  input  logic          redirectValid,
  input  logic [15:0]   redirectPC,
  input  logic          haltSeen,
  fetch_stage_if.master imem,
  output logic [15:0]   pcF,
  output logic [15:0]   instructionF,
  output logic [15:0]   incPCF,
  output logic          instrValidF,
  output logic          errF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_PRESENT, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_d;
  logic [15:0] instr_q;
  logic        err_q;
  logic        capture;
  logic        pend_redir_q, pend_redir_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        pend_halt_q, pend_halt_d;
  logic        drain_q;
  logic        redir_now;
  logic [15:0] redir_tgt;
  logic        halt_now;
  logic        unused_stall;

  // 16-bit modulo PC increment; 16'hFFFE wraps to 16'h0000.
  function automatic logic [15:0] inc_pc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  // Memory busy is already implied by the absence of imemDone.
  assign unused_stall = imem.imemStall;

  // Next-state, next-PC and pending redirect/halt bookkeeping.
  always_comb begin
    state_d      = state_q;
    pc_d         = pcF;
    capture      = 1'b0;
    pend_redir_d = pend_redir_q;
    pend_pc_d    = pend_pc_q;
    pend_halt_d  = pend_halt_q;
    // A redirect arriving now overrides any pending one; a HALT only counts
    // when no redirect is in play (otherwise it was wrong-path).
    redir_now    = redirectValid || pend_redir_q;
    redir_tgt    = redirectValid ? redirectPC : pend_pc_q;
    halt_now     = !redir_now && (haltSeen || pend_halt_q);
    case (state_q)
      S_REQ: begin
        // drain_q marks the first cycle after a reset that cut off a miss:
        // any imemDone seen then belongs to the aborted request.
        if (!drain_q) begin
          if (redirectValid) begin
            pc_d = redirectPC;
          end else if (haltSeen) begin
            state_d = S_HALTED;
          end else if (imem.imemDone) begin
            capture = 1'b1;
            state_d = S_PRESENT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem.imemDone) begin
          pend_redir_d = 1'b0;
          pend_halt_d  = 1'b0;
          if (redir_now) begin
            pc_d    = redir_tgt;
            state_d = S_REQ;
          end else if (halt_now) begin
            state_d = S_HALTED;
          end else begin
            capture = 1'b1;
            state_d = S_PRESENT;
          end
        end else begin
          pend_redir_d = redir_now;
          pend_pc_d    = redir_tgt;
          pend_halt_d  = halt_now;
        end
      end
      S_PRESENT: begin
        if (redirectValid) begin
          pc_d    = redirectPC;
          state_d = S_REQ;
        end else if (haltSeen) begin
          state_d = S_HALTED;
        end else if (!stallF) begin
          pc_d    = inc_pc(pcF);
          state_d = S_REQ;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // Control registers: FSM state, PC, pending flags, post-reset drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pcF          <= RESET_PC;
      pend_redir_q <= 1'b0;
      pend_halt_q  <= 1'b0;
      drain_q      <= (state_q == S_WAIT);
    end else begin
      state_q      <= state_d;
      pcF          <= pc_d;
      pend_redir_q <= pend_redir_d;
      pend_halt_q  <= pend_halt_d;
      drain_q      <= 1'b0;
    end
  end

  // Data registers: captured instruction/error and pending redirect target.
  always_ff @(posedge clk) begin
    if (capture) begin
      instr_q <= imem.imemData;
      err_q   <= imem.imemErr;
    end
    pend_pc_q <= pend_pc_d;
  end

  assign imem.imemReq  = rst && !drain_q && (state_q == S_REQ);
  assign imem.imemAddr = pcF;
  assign instrValidF   = (state_q == S_PRESENT);
  assign instructionF  = instrValidF ? instr_q : NOP_INSTR;
  assign errF          = instrValidF && err_q;
  assign incPCF        = inc_pc(pcF);

endmodule
